sram_32x32_host: RTL and testbench
==================================

Name: sram_32x32_host

Overview:
- Initiator-side controller for the sram_32x32 single-port RW macro.
- Converts a valid/ready request stream (read or write, one per cycle) into registered csb0/web0/addr0/din0 macro pins.
- Captures dout0 at the correct edge and returns read data through a valid/ready response queue with credit-based backpressure.
- Optional post-reset zero-fill of the array. Sits between the core-side bus adapter and the hard macro.

Parameters:
- DATA_WIDTH, 32, word width; must match the macro.
- ADDR_WIDTH, 5, address width; depth is 1<<ADDR_WIDTH.
- RSP_DEPTH, 4, response FIFO entries; power of two, >=2.
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset before accepting requests.

Ports:
- clk0  in  1  clock, shared with the macro clk0.
- rst0  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data present.
- rsp_ready  in  1  consumer takes data when valid&ready.
- rsp_rdata  out  DATA_WIDTH  read data, in request order.
- init_done  out  1  high once the clear sequence has finished (or immediately if CLEAR_ON_RESET=0).
- sram_csb0  out  1  macro chip select, active low, registered.
- sram_web0  out  1  macro write enable, active low, registered.
- sram_addr0  out  ADDR_WIDTH  macro address, registered.
- sram_din0  out  DATA_WIDTH  macro write data, registered.
- sram_dout0  in  DATA_WIDTH  macro read data.

Behaviour:
Reset values:
- sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
- rsp_valid=0, rsp_rdata=0, req_ready=0.
- init_done = !CLEAR_ON_RESET.
- FIFO empty, in-flight count 0, state = CLEAR if CLEAR_ON_RESET else RUN.

States:
- CLEAR: each cycle drive csb0=0, web0=0, din0=0, addr0=clr_ptr, then clr_ptr++.
  - After addr 2^ADDR_WIDTH-1 is issued, go to RUN and set init_done=1 the same edge.
  - req_ready=0 throughout CLEAR.
- RUN: normal operation. No other transitions; only rst0 re-enters CLEAR.

Issue (RUN):
- Accept at posedge n drives the pins for cycle n+1; the macro samples them at posedge n+1.
- A cycle with no accept drives csb0=1, web0=1; addr0/din0 hold their last value.

Read timing:
- Macro updates dout0 after negedge of cycle n+1. It goes X at posedge n+2 + hold.
- Controller samples sram_dout0 at posedge n+2 only, via a 2-stage read-tag shift register (tag set on read accept).
- Captured word enters the FIFO at posedge n+2. rsp_valid is asserted from posedge n+2 if the FIFO was empty: fall-through from FIFO head, no extra register stage. Read latency = 2 cycles.

Writes:
- Produce no response; fire-and-forget.
- Read-after-write to the same address on consecutive accepts returns the new data.

Credits:
- req_ready = (state==RUN) && (fifo_count + reads_in_flight < RSP_DEPTH).
- reads_in_flight is 0..2.
- Writes are accepted whenever state==RUN, regardless of credits.
- req_ready must not depend combinationally on req_valid or req_we.

FIFO:
- Simultaneous push and pop keeps the count unchanged.
- Pointers wrap modulo RSP_DEPTH.
- Overflow is impossible by credit construction; the bench asserts this.

Reset mid-operation:
- All state clears asynchronously and csb0 goes high immediately.
- A write already sampled by the macro may complete; in-flight read data is discarded.
- With CLEAR_ON_RESET=1 the clear sequence restarts from address 0.

Decomposition:
- Package sram_host_pkg: state enum {ST_CLEAR, ST_RUN}; localparams for default DATA_WIDTH/ADDR_WIDTH and READ_LATENCY=2.
- Sub-module sram_host_rsp_fifo: synchronous FIFO (RSP_DEPTH x DATA_WIDTH) with push, pop, count, fall-through head, async active-high reset.
- Top holds the FSM, pin registers, read-tag pipeline and credit logic.

Test Plan:
- Clear: CLEAR_ON_RESET=1, release rst0 → 32 consecutive write cycles to addr 0..31 with din0=0; init_done rises at the edge after addr 31 is issued; reading addr 17 then returns 0x00000000.
- Write/read: write addr 5 = 0xDEADBEEF, next cycle read addr 5 → rsp_valid rises exactly 2 cycles after the read accept with rsp_rdata=0xDEADBEEF.
- Streaming: reads to addr 0..7 (preloaded with value = addr*0x01010101), rsp_ready=1 → one response per cycle in order, req_ready never drops.
- Backpressure: rsp_ready=0, issue reads → exactly 4 accepted, then req_ready=0; writes are still accepted. Raise rsp_ready → 4 responses in order, and req_ready returns the cycle after the first pop.
- Reset mid-stream: assert rst0 with 2 reads in flight → sram_csb0=1 and rsp_valid=0 immediately; no stale response appears after release.
- Idle pins: no requests for 10 cycles → sram_csb0=1 and sram_web0=1 every cycle, no macro access.

Source files
------------

// File: rtl/sram_32x32_host_pkg.sv
// Shared types and constants for the sram_32x32 initiator-side controller.
package sram_host_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   // Cycles from read accept to dout0 capture.
   localparam int READ_LATENCY   = 2;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } host_state_e;

endpackage

// File: rtl/sram_32x32_host_if.sv
// Core-side request/response bus of the sram_32x32 host controller.
interface sram_32x32_host_if
   import sram_host_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  init_done;

   // Core side: issues requests, consumes responses.
   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, init_done
   );

   // Controller side.
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, init_done
   );
endinterface

// File: rtl/sram_32x32_host_rsp_fifo.sv
// Read-response FIFO with fall-through head: o_head is valid the same cycle
// the first word is pushed, with no output register.
module sram_host_rsp_fifo #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   localparam int PW        = $clog2(DEPTH),
   localparam int CW        = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic                  o_valid,
   output logic [CW-1:0]         o_count
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_push;
   logic                  w_pop;

   assign w_pop   = i_pop && (r_count != '0);
   // Full-push is blocked upstream by credits; the guard keeps state sane regardless.
   assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != '0);
   assign o_count = r_count;

   // Storage, pointers (wrap modulo DEPTH) and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sram_32x32_host.sv
// Initiator-side controller for the sram_32x32 RW macro: registers the macro
// pins, captures dout0 two cycles after a read accept and returns it through
// a credit-protected response FIFO. Optionally zero-fills the array after reset.
//
//  state    | meaning
//  ST_CLEAR | writing zero to every word, requests blocked
//  ST_RUN   | normal request/response operation
module sram_32x32_host
   import sram_host_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int RSP_DEPTH      = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk0,
   input  logic                  rst0,
   sram_32x32_host_if.slave      bus,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int CW = $clog2(RSP_DEPTH) + 1;
   localparam int SW = CW + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   host_state_e           r_state;
   host_state_e           w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_ptr;
   logic [READ_LATENCY-1:0] r_rd_tag;
   logic                  r_csb0;
   logic                  r_web0;
   logic [ADDR_WIDTH-1:0] r_addr0;
   logic [DATA_WIDTH-1:0] r_din0;

   logic [CW-1:0]         w_fifo_count;
   logic [SW-1:0]         w_inflight;
   logic                  w_credit_ok;
   logic                  w_req_ready;
   logic                  w_init_done;
   logic                  w_clr_issue;
   logic                  w_accept;
   logic                  w_rd_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_fifo_valid;
   logic [DATA_WIDTH-1:0] w_fifo_head;

   // State register; reset re-enters the clear sequence from address 0.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      else      r_state <= w_state_nxt;
   end

   // Next state: leave CLEAR on the edge that issues the last address.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_CLEAR && r_clr_ptr == LAST_ADDR) w_state_nxt = ST_RUN;
   end

   // FSM outputs: handshake ready, init flag, clear-issue strobe.
   always_comb begin
      w_req_ready = 1'b0;
      w_init_done = 1'b0;
      w_clr_issue = 1'b0;
      case (r_state)
         ST_CLEAR: w_clr_issue = 1'b1;
         ST_RUN: begin
            w_req_ready = w_credit_ok;
            w_init_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Count reads already issued whose data is not yet in the FIFO.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) w_inflight = w_inflight + SW'(r_rd_tag[i]);
   end

   assign w_credit_ok = (SW'(w_fifo_count) + w_inflight) < SW'(RSP_DEPTH);

   // Writes need no response slot, so they bypass the credit check; req_ready
   // itself only reflects read credit so it never depends on req_we.
   assign w_accept    = bus.req_valid && (r_state == ST_RUN) && (bus.req_we || w_credit_ok);
   assign w_rd_accept = w_accept && !bus.req_we;

   // Clear pointer walks the whole array once per reset.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0)             r_clr_ptr <= '0;
      else if (w_clr_issue) r_clr_ptr <= r_clr_ptr + 1'b1;
   end

   // Read-tag pipeline: the oldest stage marks the edge at which dout0 is valid.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) r_rd_tag <= '0;
      else      r_rd_tag <= {r_rd_tag[READ_LATENCY-2:0], w_rd_accept};
   end

   // Macro pin registers; idle cycles deselect and leave addr/din untouched.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         r_csb0  <= 1'b1;
         r_web0  <= 1'b1;
         r_addr0 <= '0;
         r_din0  <= '0;
      end else if (w_clr_issue) begin
         r_csb0  <= 1'b0;
         r_web0  <= 1'b0;
         r_addr0 <= r_clr_ptr;
         r_din0  <= '0;
      end else if (w_accept) begin
         r_csb0  <= 1'b0;
         r_web0  <= !bus.req_we;
         r_addr0 <= bus.req_addr;
         if (bus.req_we) r_din0 <= bus.req_wdata;
      end else begin
         r_csb0  <= 1'b1;
         r_web0  <= 1'b1;
      end
   end

   assign sram_csb0  = r_csb0;
   assign sram_web0  = r_web0;
   assign sram_addr0 = r_addr0;
   assign sram_din0  = r_din0;

   assign w_push = r_rd_tag[READ_LATENCY-1];
   assign w_pop  = w_fifo_valid && bus.rsp_ready;

   sram_host_rsp_fifo #(
      .DEPTH      (RSP_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk     (clk0),
      .rst     (rst0),
      .i_push  (w_push),
      .i_data  (sram_dout0),
      .i_pop   (w_pop),
      .o_head  (w_fifo_head),
      .o_valid (w_fifo_valid),
      .o_count (w_fifo_count)
   );

   assign bus.req_ready = w_req_ready;
   assign bus.init_done = w_init_done;
   assign bus.rsp_valid = w_fifo_valid;
   assign bus.rsp_rdata = w_fifo_head;

endmodule

// File: tb/tb_sram_32x32_host.sv
// Directed bench for sram_32x32_host with a behavioural sram_32x32 macro model.
module tb_sram_32x32_host;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk0 = 1'b0;
   logic          rst0 = 1'b1;
   logic          sram_csb0;
   logic          sram_web0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic [DW-1:0] sram_dout0;

   sram_32x32_host_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   sram_32x32_host #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .RSP_DEPTH      (4),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk0       (clk0),
      .rst0       (rst0),
      .bus        (bus),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0)
   );

   always #5 clk0 = ~clk0;

   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int acc_cnt   = 0;
   int stall_cnt = 0;
   int out_cnt   = 0;
   int max_out   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Macro model: pins sampled at posedge, dout0 valid after the following
   // negedge, then corrupted shortly after the next posedge.
   logic [DW-1:0] mem [32];
   logic          rd_pend = 1'b0;
   logic [AW-1:0] rd_addr = '0;

   initial begin
      sram_dout0 = '0;
      for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | i;
   end

   always @(posedge clk0) begin
      if (!sram_csb0) begin
         acc_cnt++;
         if (!sram_web0) mem[sram_addr0] = sram_din0;
         else begin
            rd_pend = 1'b1;
            rd_addr = sram_addr0;
         end
      end
   end

   always @(negedge clk0) begin
      if (rd_pend) begin
         sram_dout0 = mem[rd_addr];
         rd_pend    = 1'b0;
      end
   end

   always @(posedge clk0) begin
      #1;
      sram_dout0 = 32'hBAD0_BAD0;
   end

   // Response scoreboard and outstanding-read tracker.
   logic [DW-1:0] rsp_q [$];
   int            rsp_cyc [$];

   always @(posedge clk0) begin
      cyc++;
      if (!rst0) begin
         if (bus.req_valid && bus.req_ready && !bus.req_we) out_cnt++;
         if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_q.push_back(bus.rsp_rdata);
            rsp_cyc.push_back(cyc);
            out_cnt--;
         end
         if (out_cnt > max_out) max_out = out_cnt;
      end
   end

   function automatic logic [31:0] rsp_at(input int i);
      return (rsp_q.size() > i) ? rsp_q[i] : 32'hEEEE_EEEE;
   endfunction

   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input string tag);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(negedge clk0);
      while (!bus.req_ready && n < 50) begin
         n++;
         @(negedge clk0);
      end
      if (n != 0) stall_cnt++;
      if (n >= 50) chk({tag, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk0);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int c = 0;
      while (rsp_q.size() < n && c < budget) begin
         @(posedge clk0);
         #1;
         c++;
      end
   endtask

   task automatic check_clear(input string tag);
      int idx = 0;
      int bad = 0;
      int c   = 0;
      while (idx < 32 && c < 64) begin
         @(posedge clk0);
         #1;
         c++;
         if (!sram_csb0) begin
            if (sram_web0 !== 1'b0 || sram_din0 !== '0 || sram_addr0 !== AW'(idx)) bad++;
            if (bus.init_done !== (idx == 31)) bad++;
            if (idx < 31 && bus.req_ready !== 1'b0) bad++;
            idx++;
         end else if (idx > 0) bad++;
      end
      chk({tag, "_words"}, idx, 32);
      chk({tag, "_seq"}, bad, 0);
      chk({tag, "_done"}, bus.init_done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            n_acc;
      int            bad;
      int            a0;
      logic          acc;
      logic [AW-1:0] a;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;

      // Reset values
      repeat (2) @(posedge clk0);
      #1;
      chk("rst_csb",       sram_csb0, 1);
      chk("rst_web",       sram_web0, 1);
      chk("rst_addr",      sram_addr0, 0);
      chk("rst_din",       sram_din0, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_init_done", bus.init_done, 0);
      rst0 = 1'b0;

      // Zero-fill, then read a cleared word
      check_clear("clr0");
      bus.rsp_ready = 1'b1;
      rsp_q.delete();
      send(1'b0, 5'd17, '0, "rd17");
      wait_rsp(1, 10);
      chk("clr_rd17_cnt",  rsp_q.size(), 1);
      chk("clr_rd17_data", rsp_at(0), 32'h0000_0000);

      // Write then read same address on consecutive accepts
      rsp_q.delete();
      send(1'b1, 5'd5, 32'hDEAD_BEEF, "wr5");
      send(1'b0, 5'd5, '0, "rd5");
      chk("wr_rd_lat0", bus.rsp_valid, 0);
      @(posedge clk0); #1;
      chk("wr_rd_lat1", bus.rsp_valid, 0);
      @(posedge clk0); #1;
      chk("wr_rd_lat2", bus.rsp_valid, 1);
      chk("wr_rd_data", bus.rsp_rdata, 32'hDEAD_BEEF);

      // Streaming reads, one response per cycle
      for (int i = 0; i < 8; i++) send(1'b1, AW'(i), i * 32'h0101_0101, "pre");
      repeat (4) @(posedge clk0);
      #1;
      rsp_q.delete();
      rsp_cyc.delete();
      stall_cnt = 0;
      for (int i = 0; i < 8; i++) send(1'b0, AW'(i), '0, "stream");
      wait_rsp(8, 20);
      chk("stream_stalls", stall_cnt, 0);
      chk("stream_cnt", rsp_q.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("stream_d%0d", i), rsp_at(i), i * 32'h0101_0101);
      chk("stream_span", (rsp_cyc.size() == 8) ? (rsp_cyc[7] - rsp_cyc[0]) : -1, 7);

      // Backpressure: reads limited to FIFO depth, writes still accepted
      repeat (3) @(posedge clk0);
      #1;
      bus.rsp_ready = 1'b0;
      rsp_q.delete();
      max_out = 0;
      n_acc = 0;
      a = '0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = a;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk0);
         acc = bus.req_ready;
         @(posedge clk0); #1;
         if (acc) begin
            n_acc++;
            a = a + 1'b1;
            bus.req_addr = a;
         end
      end
      bus.req_valid = 1'b0;
      chk("bp_accepts",   n_acc, 4);
      chk("bp_ready_low", bus.req_ready, 0);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 5'd20;
      bus.req_wdata = 32'h1234_5678;
      @(posedge clk0); #1;
      bus.req_valid = 1'b0;
      chk("bp_wr_csb",  sram_csb0, 0);
      chk("bp_wr_web",  sram_web0, 0);
      chk("bp_wr_addr", sram_addr0, 20);
      @(posedge clk0); #1;
      chk("bp_wr_mem", mem[20], 32'h1234_5678);
      bus.rsp_ready = 1'b1;
      chk("bp_ready_pre_pop", bus.req_ready, 0);
      @(posedge clk0); #1;
      chk("bp_ready_post_pop", bus.req_ready, 1);
      wait_rsp(4, 10);
      chk("bp_rsp_cnt", rsp_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("bp_d%0d", i), rsp_at(i), i * 32'h0101_0101);
      chk("bp_no_overflow", (max_out <= 4), 1);

      // Reset with one response queued and two reads in flight
      repeat (2) @(posedge clk0);
      #1;
      bus.rsp_ready = 1'b0;
      send(1'b0, 5'd3, '0, "mid3");
      send(1'b0, 5'd1, '0, "mid1");
      send(1'b0, 5'd2, '0, "mid2");
      chk("mid_pre_csb",   sram_csb0, 0);
      chk("mid_pre_valid", bus.rsp_valid, 1);
      rst0 = 1'b1;
      #1;
      chk("mid_rst_csb",   sram_csb0, 1);
      chk("mid_rst_valid", bus.rsp_valid, 0);
      out_cnt = 0;
      rsp_q.delete();
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk0);
      #1;
      rst0 = 1'b0;
      check_clear("clr1");
      repeat (10) @(posedge clk0);
      #1;
      chk("mid_no_stale", rsp_q.size(), 0);

      // Idle pins
      a0  = acc_cnt;
      bad = 0;
      repeat (10) begin
         @(posedge clk0); #1;
         if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) bad++;
      end
      chk("idle_pins",   bad, 0);
      chk("idle_access", acc_cnt - a0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
